// File: rtl/fp16_sqrt_pkg.sv
// Shared fp16 types, constants and the special-operand classifier used around
// the shared square-root core.
package fp16_sqrt_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_QNAN  = 16'h7E00;
    localparam fp16_t FP16_PINF  = 16'h7C00;
    localparam fp16_t FP16_PZERO = 16'h0000;

    // Classifies an operand the core cannot handle. When hit is set, val is the
    // final result and the core output must be ignored. Priority matters: a
    // negative subnormal flushes to +0 before the sign test turns it into NaN.
    function automatic void fp16_sqrt_special(input fp16_t a, output logic hit, output fp16_t val);
        logic exp_zero;
        logic exp_max;
        logic mant_zero;
        exp_zero  = (a[14:10] == 5'd0);
        exp_max   = (a[14:10] == 5'h1F);
        mant_zero = (a[9:0] == 10'd0);
        hit       = 1'b1;
        val       = a;
        if (exp_zero && mant_zero) begin
            val = a;                 // sqrt(+-0) = +-0
        end else if (exp_zero) begin
            val = FP16_PZERO;        // subnormals flush to zero
        end else if (a[15]) begin
            val = FP16_QNAN;         // any negative nonzero, including -inf
        end else if (exp_max && !mant_zero) begin
            val = FP16_QNAN;
        end else if (exp_max) begin
            val = FP16_PINF;
        end else begin
            hit = 1'b0;
        end
    endfunction

endpackage

// File: rtl/fp16_Rom_sqrt.sv
// Combinational square root of a positive normal fp16 magnitude. The result
// significand is the truncated integer square root of the scaled significand,
// so it is never more than 1 ulp below the exact value. Other operand classes
// produce don't-care values and are overridden by the caller.
module fp16_Rom_sqrt (
    input  logic [14:0] mag_i,
    output logic [14:0] mag_o
);

    logic [10:0] sig;
    logic [21:0] rad;
    logic [13:0] rem;
    logic [13:0] trial;
    logic [10:0] root;
    logic [4:0]  res_exp;

    // Digit-by-digit integer square root; an odd exponent shifts one bit less so
    // the remaining exponent is even and halves exactly.
    always_comb begin
        sig   = {1'b1, mag_i[9:0]};
        rad   = mag_i[10] ? {1'b0, sig, 10'd0} : {sig, 11'd0};
        rem   = '0;
        root  = '0;
        trial = '0;
        for (int i = 0; i < 11; i++) begin
            rem   = {rem[11:0], rad[21:20]};
            rad   = {rad[19:0], 2'b00};
            trial = {1'b0, root, 2'b01};
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[9:0], 1'b1};
            end else begin
                root = {root[9:0], 1'b0};
            end
        end
        // (e + 15) >> 1 written without a carry bit that would go unused.
        res_exp = {1'b0, mag_i[14:11]} + 5'd7 + {4'd0, mag_i[10]};
        mag_o   = {res_exp, root[9:0]};
    end

endmodule

// File: rtl/sqrt_rr_arbiter.sv
// Round-robin arbiter: scans from the lane after the last accepted winner and
// only moves its pointer when the current winner is actually accepted.
module sqrt_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o
);

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    logic [ID_W-1:0] idx_v;
    logic            found;
    int              idx;

    // Pick the first requester after rr_ptr; the wrap is an explicit compare so
    // non power-of-two lane counts never alias onto a missing lane.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        idx_v      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_v = ID_W'(idx);
            if (!found && req_i[idx_v]) begin
                found          = 1'b1;
                grant_o[idx_v] = 1'b1;
                grant_id_o     = idx_v;
            end
        end
    end

    // Next pointer follows the winner only on an accepted grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i) begin
            rr_ptr_d = grant_id_o;
        end
    end

    // Pointer register; reset to the last lane so lane 0 is served first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking assignments; the combinational
        // blocks above use blocking ones because they compute in program order.
        if (!rst_ni) begin
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/fp16_sqrt_share_arb.sv
// Shares one combinational fp16 sqrt core among NUM_REQ requesters through a
// two-stage pipeline: S1 holds the accepted operand, S2 the finished result,
// and the result is steered back to the lane that issued it.
module fp16_sqrt_share_arb
    import fp16_sqrt_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ-1:0][15:0] req_data_i,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    output logic [NUM_REQ-1:0][15:0] rsp_data_o,
    output logic                     busy_o
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               stall;
    logic               s1_load;
    logic               accept;
    logic               rst_done_q;

    logic               s1_valid_q, s1_valid_d;
    fp16_t              s1_data_q,  s1_data_d;
    logic [ID_W-1:0]    s1_id_q,    s1_id_d;
    logic               s2_valid_q, s2_valid_d;
    fp16_t              s2_data_q,  s2_data_d;
    logic [ID_W-1:0]    s2_id_q,    s2_id_d;

    logic [14:0]        core_mag;
    logic               special_hit;
    fp16_t              special_val;
    fp16_t              s1_result;

    // S2 only holds when its owner is not taking the result; S1 may refill
    // whenever it is empty, which gives one entry of slack under a stall.
    assign stall       = s2_valid_q & ~rsp_ready_i[s2_id_q];
    assign s1_load     = ~stall | ~s1_valid_q;
    assign accept      = (|grant) & s1_load & rst_done_q;
    assign req_ready_o = accept ? grant : '0;
    assign busy_o      = s1_valid_q | s2_valid_q;
    assign rsp_data_o  = {NUM_REQ{s2_data_q}};

    sqrt_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_valid_i),
        .advance_i  (accept),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    fp16_Rom_sqrt u_core (
        .mag_i (s1_data_q[14:0]),
        .mag_o (core_mag)
    );

    // Special operands override the core; normal results are always positive.
    always_comb begin
        special_hit = 1'b0;
        special_val = '0;
        fp16_sqrt_special(s1_data_q, special_hit, special_val);
        s1_result = special_hit ? special_val : {1'b0, core_mag};
    end

    // Pipeline next state: S2 drains/loads and S1 refills in the same cycle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        if (!stall) begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_result;
            s2_id_d    = s1_id_q;
        end
        if (s1_load) begin
            s1_valid_d = accept;
            s1_data_d  = req_data_i[grant_id];
            s1_id_d    = grant_id;
        end
    end

    // Pipeline registers plus the flag that keeps ready low in the first cycle
    // after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_done_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            // NOTE: payload registers are reset as well, not just the valids,
            // because rsp_data_o is driven straight from S2 and must read 0.
            s1_data_q  <= '0;
            s1_id_q    <= '0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
        end else begin
            rst_done_q <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
        end
    end

    // Steer the S2 valid to the lane that issued the operand.
    always_comb begin
        rsp_valid_o = '0;
        if (s2_valid_q) begin
            rsp_valid_o[s2_id_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fp16_sqrt_share_arb.sv
// Directed and scoreboarded checks of the shared fp16 sqrt arbiter: one
// 4-lane instance for directed scenarios, one 3-lane instance for random traffic.
module tb_fp16_sqrt_share_arb;

    logic clk;
    logic rst_n;

    logic [3:0]       v4, r4, rv4, rr4;
    logic [3:0][15:0] d4i, d4o;
    logic             b4;

    logic [2:0]       v3, r3, rv3, rr3;
    logic [2:0][15:0] d3i, d3o;
    logic             b3;

    int n_cmp;
    int n_err;

    logic [15:0] op_q [3][$];

    fp16_sqrt_share_arb #(.NUM_REQ(4)) dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (v4),
        .req_ready_o (r4),
        .req_data_i  (d4i),
        .rsp_valid_o (rv4),
        .rsp_ready_i (rr4),
        .rsp_data_o  (d4o),
        .busy_o      (b4)
    );

    fp16_sqrt_share_arb #(.NUM_REQ(3)) dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (v3),
        .req_ready_o (r3),
        .req_data_i  (d3i),
        .rsp_valid_o (rv3),
        .rsp_ready_i (rr3),
        .rsp_data_o  (d3o),
        .busy_o      (b3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: special classes by rule, normal operands through real sqrt,
    // truncated to a 10-bit fraction. exact=0 allows a 1-ulp difference.
    function automatic logic [15:0] model_sqrt(input logic [15:0] a, output bit exact);
        int  e;
        int  m;
        int  ex;
        real v;
        real r;
        exact = 1'b1;
        e = int'(a[14:10]);
        m = int'(a[9:0]);
        if (e == 0 && m == 0) return a;
        if (e == 0) return 16'h0000;
        if (a[15]) return 16'h7E00;
        if (e == 31) return (m != 0) ? 16'h7E00 : 16'h7C00;
        exact = 1'b0;
        v = 1.0 + m / 1024.0;
        for (int k = 15; k < e; k++) v = v * 2.0;
        for (int k = e; k < 15; k++) v = v / 2.0;
        r  = $sqrt(v);
        ex = 0;
        while (r >= 2.0) begin r = r / 2.0; ex++; end
        while (r < 1.0) begin r = r * 2.0; ex--; end
        return {1'b0, 5'(ex + 15), 10'($rtoi((r - 1.0) * 1024.0))};
    endfunction

    function automatic bit within_ulp(input logic [15:0] act, input logic [15:0] exp);
        int d;
        d = int'(act) - int'(exp);
        return (d >= -1) && (d <= 1);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v4 = '0; rr4 = '1; v3 = '0; rr3 = '1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        v4  = '1;
        rr4 = '1;
        d4i = {4{16'h4400}};
        @(negedge clk); #1;
        n_cmp++; if (r4 !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", r4); end
        n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rv4); end
        n_cmp++; if (b4 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", b4); end
        n_cmp++; if (d4o !== 64'd0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", d4o); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (r4 !== 4'b0000) begin n_err++; $display("FAIL release_ready: got %b want 0000", r4); end
        n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL release_rsp_valid: got %b want 0000", rv4); end
        @(negedge clk);
        v4 = '0;
        #1;
        n_cmp++; if (b4 !== 1'b0) begin n_err++; $display("FAIL release_no_accept: busy got %b want 0", b4); end
    endtask

    task automatic test_single();
        @(negedge clk);
        d4i[0] = 16'h4400;
        v4     = 4'b0001;
        rr4    = '1;
        #1;
        n_cmp++; if (r4 !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", r4); end
        @(negedge clk);
        v4 = '0;
        #1;
        n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL single_early_valid: got %b want 0000", rv4); end
        n_cmp++; if (b4 !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", b4); end
        @(negedge clk); #1;
        n_cmp++; if (rv4 !== 4'b0001) begin n_err++; $display("FAIL single_rsp_valid: got %b want 0001", rv4); end
        n_cmp++; if (!within_ulp(d4o[0], 16'h4000)) begin n_err++; $display("FAIL single_data: got %h want 4000 +-1", d4o[0]); end
        @(negedge clk); #1;
        n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL single_drain: got %b want 0000", rv4); end
        n_cmp++; if (b4 !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", b4); end
    endtask

    task automatic test_specials();
        logic [15:0] ops  [13];
        logic [15:0] exps [13];
        bit          tol  [13];
        ops  = '{16'h0000, 16'h8000, 16'hBC00, 16'h7C01, 16'h7C00, 16'h0001, 16'h8001,
                 16'hFC00, 16'h3C00, 16'h4200, 16'h4800, 16'h7BFF, 16'h0400};
        exps = '{16'h0000, 16'h8000, 16'h7E00, 16'h7E00, 16'h7C00, 16'h0000, 16'h0000,
                 16'h7E00, 16'h3C00, 16'h3EED, 16'h41A8, 16'h5BFF, 16'h2000};
        tol  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        rr4  = '1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            d4i[0] = ops[i];
            v4     = 4'b0001;
            @(negedge clk);
            v4 = '0;
            @(negedge clk); #1;
            n_cmp++; if (rv4 !== 4'b0001) begin n_err++; $display("FAIL special_valid op=%h: got %b want 0001", ops[i], rv4); end
            n_cmp++;
            if (tol[i] ? !within_ulp(d4o[0], exps[i]) : (d4o[0] !== exps[i])) begin
                n_err++; $display("FAIL special_data op=%h: got %h want %h", ops[i], d4o[0], exps[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [15:0] res [4];
        int          lane;
        res = '{16'h4000, 16'h3C00, 16'h41A8, 16'h3EED};
        apply_reset();
        d4i[0] = 16'h4400; d4i[1] = 16'h3C00; d4i[2] = 16'h4800; d4i[3] = 16'h4200;
        rr4 = '1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) v4 = 4'b1111;
            #1;
            n_cmp++; if (r4 !== 4'(1 << (c % 4))) begin n_err++; $display("FAIL rr_grant c=%0d: got %b want %b", c, r4, 4'(1 << (c % 4))); end
            if (c >= 2) begin
                lane = (c - 2) % 4;
                n_cmp++; if (rv4 !== 4'(1 << lane)) begin n_err++; $display("FAIL rr_rsp_valid c=%0d: got %b want %b", c, rv4, 4'(1 << lane)); end
                n_cmp++; if (d4o[lane] !== res[lane]) begin n_err++; $display("FAIL rr_rsp_data c=%0d: got %h want %h", c, d4o[lane], res[lane]); end
            end else begin
                n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL rr_fill c=%0d: got %b want 0000", c, rv4); end
            end
        end
        @(negedge clk);
        v4 = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        rr4 = 4'b1101; v4 = 4'b0010; d4i[1] = 16'h4400;
        #1;
        n_cmp++; if (r4 !== 4'b0010) begin n_err++; $display("FAIL bp_accept1: got %b want 0010", r4); end
        @(negedge clk);
        v4 = 4'b0100; d4i[2] = 16'h3C00;
        #1;
        n_cmp++; if (r4 !== 4'b0100) begin n_err++; $display("FAIL bp_accept2: got %b want 0100", r4); end
        @(negedge clk);
        d4i[2] = 16'h4800;
        for (int c = 2; c <= 6; c++) begin
            if (c > 2) @(negedge clk);
            #1;
            n_cmp++; if (r4 !== 4'b0000) begin n_err++; $display("FAIL bp_ready_low c=%0d: got %b want 0000", c, r4); end
            n_cmp++; if (rv4 !== 4'b0010) begin n_err++; $display("FAIL bp_hold_valid c=%0d: got %b want 0010", c, rv4); end
            n_cmp++; if (d4o[1] !== 16'h4000) begin n_err++; $display("FAIL bp_hold_data c=%0d: got %h want 4000", c, d4o[1]); end
        end
        @(negedge clk);
        rr4 = '1;
        #1;
        n_cmp++; if (rv4 !== 4'b0010) begin n_err++; $display("FAIL bp_release_valid: got %b want 0010", rv4); end
        n_cmp++; if (r4 !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready: got %b want 0100", r4); end
        @(negedge clk);
        d4i[2] = 16'h4200;
        #1;
        n_cmp++; if (rv4 !== 4'b0100 || d4o[2] !== 16'h3C00) begin n_err++; $display("FAIL bp_out1: got %b/%h want 0100/3c00", rv4, d4o[2]); end
        n_cmp++; if (r4 !== 4'b0100) begin n_err++; $display("FAIL bp_stream_ready: got %b want 0100", r4); end
        @(negedge clk);
        v4 = '0;
        #1;
        n_cmp++; if (rv4 !== 4'b0100 || d4o[2] !== 16'h41A8) begin n_err++; $display("FAIL bp_out2: got %b/%h want 0100/41a8", rv4, d4o[2]); end
        @(negedge clk); #1;
        n_cmp++; if (rv4 !== 4'b0100 || d4o[2] !== 16'h3EED) begin n_err++; $display("FAIL bp_out3: got %b/%h want 0100/3eed", rv4, d4o[2]); end
        @(negedge clk); #1;
        n_cmp++; if (rv4 !== 4'b0000 || b4 !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b busy %b want 0000 busy 0", rv4, b4); end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        d4i = {4{16'h4400}};
        rr4 = '0;
        @(negedge clk);
        v4 = 4'b0001;
        #1;
        n_cmp++; if (r4 !== 4'b0001) begin n_err++; $display("FAIL mid_accept0: got %b want 0001", r4); end
        @(negedge clk);
        v4 = 4'b0010;
        #1;
        n_cmp++; if (r4 !== 4'b0010) begin n_err++; $display("FAIL mid_accept1: got %b want 0010", r4); end
        @(negedge clk);
        v4 = '0;
        #1;
        n_cmp++; if (rv4 !== 4'b0001 || b4 !== 1'b1) begin n_err++; $display("FAIL mid_full: got %b busy %b want 0001 busy 1", rv4, b4); end
        #2;
        rst_n = 1'b0;
        v4    = 4'b1111;
        #1;
        n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0000", rv4); end
        n_cmp++; if (b4 !== 1'b0 || r4 !== 4'b0000) begin n_err++; $display("FAIL mid_rst_idle: busy %b ready %b want 0/0000", b4, r4); end
        @(negedge clk);
        rst_n = 1'b1;
        rr4   = '1;
        #1;
        n_cmp++; if (r4 !== 4'b0000) begin n_err++; $display("FAIL mid_release_ready: got %b want 0000", r4); end
        @(negedge clk); #1;
        n_cmp++; if (r4 !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant: got %b want 0001", r4); end
        @(negedge clk);
        v4 = '0;
        #1;
        n_cmp++; if (rv4 !== 4'b0000) begin n_err++; $display("FAIL mid_no_stale: got %b want 0000", rv4); end
        @(negedge clk); #1;
        n_cmp++; if (rv4 !== 4'b0001 || d4o[0] !== 16'h4000) begin n_err++; $display("FAIL mid_reissue: got %b/%h want 0001/4000", rv4, d4o[0]); end
        @(negedge clk); #1;
        n_cmp++; if (rv4 !== 4'b0000 || b4 !== 1'b0) begin n_err++; $display("FAIL mid_drained: got %b busy %b want 0000 busy 0", rv4, b4); end
    endtask

    task automatic test_random();
        bit          acc [3];
        int          issued;
        int          accepted;
        int          cycles;
        bit          pending;
        bit          ex;
        logic [15:0] op;
        logic [15:0] expv;
        apply_reset();
        acc      = '{0, 0, 0};
        issued   = 0;
        accepted = 0;
        cycles   = 0;
        pending  = 1'b0;
        while ((accepted < 10000 || pending) && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) v3[i] = 1'b0;
                if (!v3[i] && issued < 10000 && $urandom_range(0, 3) != 0) begin
                    v3[i]  = 1'b1;
                    d3i[i] = 16'($urandom);
                    issued++;
                end
                rr3[i] = ($urandom_range(0, 3) != 0);
            end
            #1;
            n_cmp++; if ((r3 & ~v3) != 3'b000 || !$onehot0(r3)) begin n_err++; $display("FAIL rnd_ready: got %b valid %b", r3, v3); end
            n_cmp++; if (!$onehot0(rv3)) begin n_err++; $display("FAIL rnd_rsp_onehot: got %b", rv3); end
            for (int i = 0; i < 3; i++) begin
                acc[i] = v3[i] & r3[i];
                if (acc[i]) begin
                    op_q[i].push_back(d3i[i]);
                    accepted++;
                end
                if (rv3[i] && rr3[i]) begin
                    n_cmp++;
                    if (op_q[i].size() == 0) begin
                        n_err++; $display("FAIL rnd_unexpected id=%0d: got %h want none", i, d3o[i]);
                    end else begin
                        op   = op_q[i].pop_front();
                        expv = model_sqrt(op, ex);
                        if (ex ? (d3o[i] !== expv) : !within_ulp(d3o[i], expv)) begin
                            n_err++; $display("FAIL rnd_data id=%0d op=%h: got %h want %h", i, op, d3o[i], expv);
                        end
                    end
                end
            end
            pending = (b3 !== 1'b0) || (op_q[0].size() + op_q[1].size() + op_q[2].size() != 0);
        end
        n_cmp++; if (cycles >= 60000) begin n_err++; $display("FAIL rnd_timeout: got %0d accepted want 10000", accepted); end
        v3  = '0;
        rr3 = '1;
        n_cmp++;
        if (op_q[0].size() + op_q[1].size() + op_q[2].size() != 0) begin
            n_err++; $display("FAIL rnd_lost: got %0d outstanding want 0", op_q[0].size() + op_q[1].size() + op_q[2].size());
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        v4 = '0; rr4 = '1; d4i = '0;
        v3 = '0; rr3 = '1; d3i = '0;
        test_reset();
        test_single();
        test_specials();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
